// File: rtl/div64by32.sv
// Sequential 64/32 unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero and quotient overflow are flagged through err with done.
module div64by32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        err,
  output logic        done,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [W:0]    diff_c;

  // P < D is held through ITER, so one extra bit covers the trial subtraction.
  assign diff_c = {p_q, q_q[W-1]} - {1'b0, d_q};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = dataa[2*W-1:W];
          q_d     = dataa[W-1:0];
          d_d     = datab;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (d_q == '0) begin
          quot_d  = '1;
          rem_d   = q_q;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (p_q >= d_q) begin
          quot_d  = '1;
          rem_d   = '1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!diff_c[W]) begin
          p_d = diff_c[W-1:0];
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          p_d = {p_q[W-2:0], q_q[W-1]};
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          quot_d  = q_d;
          rem_d   = p_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
